score_sequencer: RTL and testbench

- Plays a stored two-voice score.
- Fetches event words from a synchronous score ROM and drives the noteA/restA/noteB/restB inputs of the dual tone generator.
- Paces itself on the generator's 48 kHz next_val strobe.
- Sits between the score memory and the tone generator. It is the producer side of the note/rest interface.

---
 rtl/score_sequencer.sv | 175 +++++++++++++++++
 tb/tb_score_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// Two-voice score player: fetches 21-bit event words from a synchronous ROM and drives note/rest per voice.
// First note lands two edges after start; all timing is paced by next_val (no backpressure on the ROM side).
module score_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int TICK_DIV  = 480,
  parameter int GAP_TICKS = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              next_val,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [20:0]       rom_data,
  output logic [6:0]        noteA,
  output logic              restA,
  output logic [6:0]        noteB,
  output logic              restB,
  output logic              busy,
  output logic              done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [10:0]   GAP_EDGE = 11'(GAP_TICKS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [6:0]        note_a_q, note_a_d, note_b_q, note_b_d;
  logic              rest_a_q, rest_a_d, rest_b_q, rest_b_d;
  logic              voice_q, voice_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              tick;

  logic        w_end, w_voice, w_rest;
  logic [6:0]  w_note;
  logic [10:0] w_dur;

  assign w_end   = rom_data[20];
  assign w_voice = rom_data[19];
  assign w_rest  = rom_data[18];
  assign w_note  = rom_data[17:11];
  assign w_dur   = rom_data[10:0];

  assign tick = (state_q != IDLE) && next_val && (pre_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    note_a_d = note_a_q;
    note_b_d = note_b_q;
    rest_a_d = rest_a_q;
    rest_b_d = rest_b_q;
    voice_d  = voice_q;
    busy_d   = busy_q;
    done_d   = done_q;

    if (state_q != IDLE && next_val) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = FETCH;
          addr_d  = '0;
          pre_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (w_end) begin
          if (loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            rest_a_d = 1'b1;
            rest_b_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          voice_d = w_voice;
          if (w_voice) begin
            note_b_d = w_note;
            rest_b_d = w_rest;
          end else begin
            note_a_d = w_note;
            rest_a_d = w_rest;
          end
          addr_d = addr_q + ADDR_W'(1);
          // A tick landing in this cycle is deliberately not applied to the new duration.
          if (w_dur == 11'd0) begin
            state_d = FETCH;
          end else begin
            cnt_d   = w_dur;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cnt_d = cnt_q - 11'd1;
          if (cnt_q == 11'd1) state_d = FETCH;
          // Articulation gap: silence the current voice from here until its next word loads.
          if (GAP_TICKS > 0 && cnt_q == GAP_EDGE) begin
            if (voice_q) rest_b_d = 1'b1;
            else         rest_a_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop && state_q != IDLE) begin
      state_d  = IDLE;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      note_a_d = note_a_q;
      note_b_d = note_b_q;
      voice_d  = voice_q;
      rest_a_d = 1'b1;
      rest_b_d = 1'b1;
      busy_d   = 1'b0;
      done_d   = done_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pre_q    <= '0;
      cnt_q    <= '0;
      note_a_q <= 7'd64;
      note_b_q <= 7'd64;
      rest_a_q <= 1'b1;
      rest_b_q <= 1'b1;
      voice_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      note_a_q <= note_a_d;
      note_b_q <= note_b_d;
      rest_a_q <= rest_a_d;
      rest_b_q <= rest_b_d;
      voice_q  <= voice_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign noteA    = note_a_q;
  assign restA    = rest_a_q;
  assign noteB    = note_b_q;
  assign restB    = rest_b_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: cycle table for basic playback plus hand sequences for timing corners.
module tb_score_sequencer;
  localparam int AW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          next_val = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [20:0]   rom_data;
  logic [6:0]    noteA, noteB;
  logic          restA, restB, busy, done;
  logic [20:0]   rom [256];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic st, sp, nv;
    logic [6:0] na; logic ra;
    logic [6:0] nb; logic rb;
    logic bz, dn;
    logic [7:0] ad;
  } vec_t;
  vec_t vecs[$];

  score_sequencer #(.ADDR_W(AW), .TICK_DIV(4), .GAP_TICKS(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .next_val(next_val),
    .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .noteA(noteA), .restA(restA), .noteB(noteB), .restB(restB),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) rom_data <= rom[rom_addr];

  function automatic logic [20:0] w(input logic e, input logic v, input logic r,
                                    input logic [6:0] n, input logic [10:0] d);
    return {e, v, r, n, d};
  endfunction

  function automatic logic [31:0] outs();
    return {6'd0, noteA, restA, noteB, restB, busy, done, rom_addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic nv,
                     input logic [6:0] na, input logic ra, input logic [6:0] nb, input logic rb,
                     input logic bz, input logic dn, input logic [7:0] ad);
    vecs.push_back('{st, sp, nv, na, ra, nb, rb, bz, dn, ad});
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; next_val = 1'b0;
    cyc(); cyc();
    sys_rst_n = 1'b1;
    cyc();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic start_play();
    start = 1'b1; cyc(); start = 1'b0; cyc(); cyc();
  endtask

  // Each pulse is followed by three quiet cycles; reports the pulse where restA is first seen
  // high right after the pulse edge, and the pulse after which noteB reaches nb_target.
  task automatic watch(input int maxp, input logic [6:0] nb_target,
                       output int rest_rise, output int nb_at);
    rest_rise = -1;
    nb_at = -1;
    for (int p = 1; p <= maxp && nb_at < 0; p++) begin
      next_val = 1'b1; cyc(); next_val = 1'b0;
      if (restA && rest_rise < 0) rest_rise = p;
      cyc(); cyc(); cyc();
      if (noteB == nb_target) nb_at = p;
    end
  endtask

  initial begin
    int rr, nb, errs;

    // st sp nv | noteA restA noteB restB busy done addr
    add(1,0,0, 64,1,64,1, 1,0, 0);
    add(0,0,0, 64,1,64,1, 1,0, 0);
    add(0,0,0, 64,0,64,1, 1,0, 1);
    for (int i = 0; i < 3; i++) add(0,0,1, 64,0,64,1, 1,0, 1);
    for (int i = 0; i < 9; i++) add(0,0,1, 64,1,64,1, 1,0, 1);
    add(0,0,0, 64,1,64,1, 1,0, 1);
    add(0,0,0, 64,1,67,0, 1,0, 2);
    add(0,0,0, 64,1,67,0, 1,0, 2);
    add(0,0,0, 64,1,67,1, 0,1, 2);
    add(0,0,1, 64,1,67,1, 0,1, 2);
    add(1,1,0, 64,1,67,1, 0,1, 2);
    add(1,0,0, 64,1,67,1, 1,0, 0);
    add(0,1,0, 64,1,67,1, 0,0, 0);
    add(0,0,0, 64,1,67,1, 0,0, 0);

    clear_rom();
    rom[0] = w(0, 0, 0, 7'd64, 11'd3);
    rom[1] = w(0, 1, 0, 7'd67, 11'd0);
    rom[2] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset();
    check("reset_state", outs(), {6'd0, 7'd64, 1'b1, 7'd64, 1'b1, 1'b0, 1'b0, 8'd0});

    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; next_val = vecs[i].nv;
      cyc();
      check($sformatf("vec%0d", i), outs(),
            {6'd0, vecs[i].na, vecs[i].ra, vecs[i].nb, vecs[i].rb, vecs[i].bz, vecs[i].dn, vecs[i].ad});
    end
    start = 1'b0; stop = 1'b0; next_val = 1'b0;

    // Long note: gap starts on pulse 12, next word fetched on pulse 20
    clear_rom();
    rom[0] = w(0, 0, 0, 7'd60, 11'd5);
    rom[1] = w(0, 1, 0, 7'd50, 11'd0);
    rom[2] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset(); start_play();
    check("gap_first_note", {noteA, restA}, {7'd60, 1'b0});
    watch(30, 7'd50, rr, nb);
    check("gap_rise_pulse", rr, 12);
    check("gap_fetch_pulse", nb, 20);

    // Rest word: restA high throughout, no gap
    clear_rom();
    rom[0] = w(0, 0, 1, 7'd55, 11'd4);
    rom[1] = w(0, 1, 0, 7'd51, 11'd0);
    rom[2] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset(); start_play();
    check("rest_word_load", {noteA, restA}, {7'd55, 1'b1});
    watch(30, 7'd51, rr, nb);
    check("rest_word_rise", rr, 1);
    check("rest_word_fetch", nb, 16);

    // Short note (dur == GAP_TICKS): no gap at all
    clear_rom();
    rom[0] = w(0, 0, 0, 7'd61, 11'd2);
    rom[1] = w(0, 1, 0, 7'd52, 11'd0);
    rom[2] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset(); start_play();
    watch(30, 7'd52, rr, nb);
    check("short_no_gap", rr, -1);
    check("short_fetch", nb, 8);
    check("short_resta_after", restA, 1'b0);

    // Tick landing in LOAD must not shorten the newly loaded duration
    clear_rom();
    rom[0] = w(0, 1, 0, 7'd20, 11'd0);
    rom[1] = w(0, 0, 0, 7'd62, 11'd1);
    rom[2] = w(0, 1, 0, 7'd33, 11'd0);
    rom[3] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    next_val = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    next_val = 1'b0;
    cyc(); cyc(); cyc();
    check("load_tick_held", {noteA, noteB}, {7'd62, 7'd20});
    next_val = 1'b1; cyc(); next_val = 1'b0;
    cyc(); cyc();
    check("load_tick_release", noteB, 7'd33);

    // Loop: END at address 5 restarts at 0, done stays low
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = w(0, 1'(i), 0, 7'(10 + i), 11'd0);
    rom[5] = w(1, 0, 0, 7'd0, 11'd0);
    loop_en = 1'b1;
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    errs = 0;
    for (int m = 0; m < 15; m++) begin
      if (rom_addr != 8'(m % 6) || done) errs++;
      cyc(); cyc();
    end
    check("loop_sequence", errs, 0);
    check("loop_busy", {busy, done}, 2'b10);
    loop_en = 1'b0;

    // No END: address wraps 255 -> 0
    for (int i = 0; i < 256; i++) rom[i] = w(0, 0, 0, 7'(i), 11'd0);
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    errs = 0;
    for (int m = 0; m < 258; m++) begin
      if (rom_addr != 8'(m)) errs++;
      cyc(); cyc();
    end
    check("wrap_sequence", errs, 0);
    check("wrap_noteA", noteA, 7'd1);

    // Stop mid-note, then replay from address 0
    clear_rom();
    rom[0] = w(0, 0, 0, 7'd70, 11'd5);
    rom[1] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset(); start_play();
    next_val = 1'b1; cyc(); cyc(); next_val = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_outputs", {noteA, restA, restB, busy, done}, {7'd70, 1'b1, 1'b1, 1'b0, 1'b0});
    start = 1'b1; cyc(); start = 1'b0;
    check("restart_e0", {restA, busy, rom_addr}, {1'b1, 1'b1, 8'd0});
    cyc();
    check("restart_e1", restA, 1'b1);
    cyc();
    check("restart_e2", {noteA, restA, rom_addr}, {7'd70, 1'b0, 8'd1});

    // Asynchronous reset during HOLD
    clear_rom();
    rom[0] = w(0, 1, 0, 7'd40, 11'd0);
    rom[1] = w(0, 0, 0, 7'd70, 11'd5);
    rom[2] = w(1, 0, 0, 7'd0, 11'd0);
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    check("pre_reset_hold", {noteA, restA, noteB, busy}, {7'd70, 1'b0, 7'd40, 1'b1});
    #2 sys_rst_n = 1'b0;
    #1 check("async_reset", outs(), {6'd0, 7'd64, 1'b1, 7'd64, 1'b1, 1'b0, 1'b0, 8'd0});
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc();
    check("post_reset_idle", {busy, done, rom_addr}, {1'b0, 1'b0, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
